// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent runtime-programmable integer clock dividers with
// period strobe, lock and pending status. Define CLKDIV_SYNC_EN to add sync_i realignment.
module clkdiv_multi #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEF_DIV      = 2,
  parameter int unsigned LOCK_PERIODS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
`ifdef CLKDIV_SYNC_EN
  input  logic                   sync_i,
`endif
  input  logic [NCH*DIV_W-1:0]   div_i,
  input  logic [NCH-1:0]         load_i,
  output logic [NCH-1:0]         clk_o,
  output logic [NCH-1:0]         stb_o,
  output logic [NCH-1:0]         locked_o,
  output logic [NCH-1:0]         pend_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_PERIODS);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_act, w_act_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_pend, w_pend_nxt;
    logic             r_pend_v, w_pend_v_nxt;
    logic [3:0]       r_lock_cnt, w_lock_nxt;
    logic             r_clk, r_stb, r_locked;
    logic             w_clk_nxt, w_stb_nxt, w_locked_nxt;
    logic [DIV_W-1:0] w_slice, w_ld_val, w_cand;
    logic [DIV_W:0]   w_half;
    logic             w_bound;

    assign w_slice  = div_i[n*DIV_W +: DIV_W];
    assign w_ld_val = (w_slice < DIV_MIN) ? DIV_MIN : w_slice;
    assign w_bound  = (r_cnt == r_act - DIV_W'(1));

    always_comb begin
      w_state_nxt  = r_state;
      w_act_nxt    = r_act;
      w_cnt_nxt    = r_cnt;
      w_pend_nxt   = r_pend;
      w_pend_v_nxt = r_pend_v;
      w_lock_nxt   = r_lock_cnt;
      w_cand       = r_act;
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt  = '0;
          w_lock_nxt = '0;
          if (load_i[n]) w_act_nxt = w_ld_val;
          if (en_i) w_state_nxt = S_RUN;
        end
        default: begin
          if (!en_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_lock_nxt  = '0;
            if (load_i[n]) begin
              w_pend_nxt   = w_ld_val;
              w_pend_v_nxt = 1'b1;
            end
          end else if (w_bound) begin
            // A load on the boundary edge bypasses pend and wins over an older pend value
            w_cnt_nxt = '0;
            if (load_i[n]) begin
              w_act_nxt    = w_ld_val;
              w_pend_v_nxt = 1'b0;
              w_lock_nxt   = '0;
            end else if (r_pend_v) begin
              w_act_nxt    = r_pend;
              w_pend_v_nxt = 1'b0;
              w_lock_nxt   = '0;
            end else if (r_lock_cnt < LOCK_MAX) begin
              w_lock_nxt = r_lock_cnt + 4'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + DIV_W'(1);
            if (load_i[n]) begin
              w_pend_nxt   = w_ld_val;
              w_pend_v_nxt = 1'b1;
            end
          end
        end
      endcase
`ifdef CLKDIV_SYNC_EN
      if (sync_i && en_i) begin
        w_cand       = load_i[n] ? w_ld_val : (r_pend_v ? r_pend : r_act);
        w_state_nxt  = S_RUN;
        w_cnt_nxt    = '0;
        w_act_nxt    = w_cand;
        w_pend_v_nxt = 1'b0;
        if (w_cand != r_act || r_state == S_IDLE) w_lock_nxt = '0;
        else                                      w_lock_nxt = r_lock_cnt;
      end
`endif
      w_half       = ({1'b0, w_act_nxt} + (DIV_W+1)'(1)) >> 1;
      w_clk_nxt    = 1'b0;
      w_stb_nxt    = 1'b0;
      w_locked_nxt = 1'b0;
      if (w_state_nxt == S_RUN) begin
        w_clk_nxt    = ({1'b0, w_cnt_nxt} < w_half);
        w_stb_nxt    = (w_cnt_nxt == '0);
        w_locked_nxt = (w_lock_nxt == LOCK_MAX);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state    <= S_IDLE;
        r_act      <= DIV_W'(DEF_DIV);
        r_cnt      <= '0;
        r_pend     <= '0;
        r_pend_v   <= 1'b0;
        r_lock_cnt <= '0;
        r_clk      <= 1'b0;
        r_stb      <= 1'b0;
        r_locked   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_act      <= w_act_nxt;
        r_cnt      <= w_cnt_nxt;
        r_pend     <= w_pend_nxt;
        r_pend_v   <= w_pend_v_nxt;
        r_lock_cnt <= w_lock_nxt;
        r_clk      <= w_clk_nxt;
        r_stb      <= w_stb_nxt;
        r_locked   <= w_locked_nxt;
      end
    end

    assign clk_o[n]    = r_clk;
    assign stb_o[n]    = r_stb;
    assign locked_o[n] = r_locked;
    assign pend_o[n]   = r_pend_v;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (NCH=2, DIV_W=8, DEF_DIV=2, LOCK_PERIODS=4).
module tb_clkdiv_multi;
  logic        clk, rst, en;
  logic [15:0] div;
  logic [1:0]  load;
  logic [1:0]  clk_o, stb_o, locked_o, pend_o;
`ifdef CLKDIV_SYNC_EN
  logic        sync;
`endif
  int n_cmp = 0;
  int n_err = 0;

  clkdiv_multi #(.NCH(2), .DIV_W(8), .DEF_DIV(2), .LOCK_PERIODS(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
`ifdef CLKDIV_SYNC_EN
    .sync_i(sync),
`endif
    .div_i(div), .load_i(load),
    .clk_o(clk_o), .stb_o(stb_o), .locked_o(locked_o), .pend_o(pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (clk_o !== 2'b00)    begin n_err++; $display("FAIL reset_clk: got %b expected 00", clk_o); end
    n_cmp++; if (stb_o !== 2'b00)    begin n_err++; $display("FAIL reset_stb: got %b expected 00", stb_o); end
    n_cmp++; if (locked_o !== 2'b00) begin n_err++; $display("FAIL reset_locked: got %b expected 00", locked_o); end
    n_cmp++; if (pend_o !== 2'b00)   begin n_err++; $display("FAIL reset_pend: got %b expected 00", pend_o); end
  endtask

  task automatic test_default();
    logic e;
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e = (i % 2 == 1);
      n_cmp++; if (clk_o !== {e, e}) begin n_err++; $display("FAIL def_clk e%0d: got %b expected %b", i, clk_o, {e, e}); end
      n_cmp++; if (stb_o !== {e, e}) begin n_err++; $display("FAIL def_stb e%0d: got %b expected %b", i, stb_o, {e, e}); end
      e = (i == 9);
      n_cmp++; if (locked_o !== {e, e}) begin n_err++; $display("FAIL def_locked e%0d: got %b expected %b", i, locked_o, {e, e}); end
    end
  endtask

  task automatic test_load_mid();
    logic e;
    div[7:0] = 8'd5; load = 2'b01;
    tick();
    load = 2'b00;
    n_cmp++; if (pend_o[0] !== 1'b1)   begin n_err++; $display("FAIL load5_pend: got %b expected 1", pend_o[0]); end
    n_cmp++; if (locked_o[0] !== 1'b1) begin n_err++; $display("FAIL load5_keep_locked: got %b expected 1", locked_o[0]); end
    n_cmp++; if (clk_o[0] !== 1'b0)    begin n_err++; $display("FAIL load5_clk_pre: got %b expected 0", clk_o[0]); end
    for (int k = 0; k <= 24; k++) begin
      tick();
      e = ((k % 5) < 3);
      n_cmp++; if (clk_o[0] !== e) begin n_err++; $display("FAIL load5_clk k%0d: got %b expected %b", k, clk_o[0], e); end
      e = ((k % 5) == 0);
      n_cmp++; if (stb_o[0] !== e) begin n_err++; $display("FAIL load5_stb k%0d: got %b expected %b", k, stb_o[0], e); end
      e = (k >= 20);
      n_cmp++; if (locked_o[0] !== e) begin n_err++; $display("FAIL load5_locked k%0d: got %b expected %b", k, locked_o[0], e); end
      n_cmp++; if (pend_o[0] !== 1'b0) begin n_err++; $display("FAIL load5_pend k%0d: got %b expected 0", k, pend_o[0]); end
    end
  endtask

  task automatic test_sanitise();
    logic e;
    div[7:0] = 8'd0; load = 2'b01;   // lands on the boundary edge
    tick();
    load = 2'b00;
    n_cmp++; if (pend_o[0] !== 1'b0)   begin n_err++; $display("FAIL coinc_pend: got %b expected 0", pend_o[0]); end
    n_cmp++; if (stb_o[0] !== 1'b1)    begin n_err++; $display("FAIL coinc_stb: got %b expected 1", stb_o[0]); end
    n_cmp++; if (locked_o[0] !== 1'b0) begin n_err++; $display("FAIL coinc_locked: got %b expected 0", locked_o[0]); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      e = (j % 2 == 0);
      n_cmp++; if (clk_o[0] !== e) begin n_err++; $display("FAIL div0_clk j%0d: got %b expected %b", j, clk_o[0], e); end
      n_cmp++; if (stb_o[0] !== e) begin n_err++; $display("FAIL div0_stb j%0d: got %b expected %b", j, stb_o[0], e); end
      n_cmp++; if (pend_o[0] !== 1'b0) begin n_err++; $display("FAIL div0_pend j%0d: got %b expected 0", j, pend_o[0]); end
    end
    div[7:0] = 8'd1; load = 2'b01;
    tick();
    load = 2'b00;
    n_cmp++; if (pend_o[0] !== 1'b1) begin n_err++; $display("FAIL div1_pend: got %b expected 1", pend_o[0]); end
    tick();
    n_cmp++; if (pend_o[0] !== 1'b0) begin n_err++; $display("FAIL div1_pend_clr: got %b expected 0", pend_o[0]); end
    n_cmp++; if (stb_o[0] !== 1'b1)  begin n_err++; $display("FAIL div1_stb: got %b expected 1", stb_o[0]); end
    tick();
    n_cmp++; if (clk_o[0] !== 1'b0)  begin n_err++; $display("FAIL div1_clk: got %b expected 0", clk_o[0]); end
  endtask

  task automatic test_div255();
    logic e;
    int hi = 0;
    div[7:0] = 8'd255; load = 2'b01;   // coincides with the div=2 boundary
    tick();
    load = 2'b00;
    n_cmp++; if (stb_o[0] !== 1'b1)  begin n_err++; $display("FAIL d255_stb0: got %b expected 1", stb_o[0]); end
    n_cmp++; if (pend_o[0] !== 1'b0) begin n_err++; $display("FAIL d255_pend: got %b expected 0", pend_o[0]); end
    if (clk_o[0] === 1'b1) hi++;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255 && clk_o[0] === 1'b1) hi++;
      e = ((k % 255) < 128);
      n_cmp++; if (clk_o[0] !== e) begin n_err++; $display("FAIL d255_clk k%0d: got %b expected %b", k, clk_o[0], e); end
      e = ((k % 255) == 0);
      n_cmp++; if (stb_o[0] !== e) begin n_err++; $display("FAIL d255_stb k%0d: got %b expected %b", k, stb_o[0], e); end
    end
    n_cmp++; if (hi != 128) begin n_err++; $display("FAIL d255_high_time: got %0d expected 128", hi); end
  endtask

  task automatic test_two_loads();
    logic e;
    div[7:0] = 8'd7; load = 2'b01;
    tick();
    div[7:0] = 8'd3;
    tick();
    load = 2'b00;
    n_cmp++; if (pend_o[0] !== 1'b1) begin n_err++; $display("FAIL two_pend: got %b expected 1", pend_o[0]); end
    repeat (252) tick();
    n_cmp++; if (pend_o[0] !== 1'b1) begin n_err++; $display("FAIL two_pend_hold: got %b expected 1", pend_o[0]); end
    n_cmp++; if (clk_o[0] !== 1'b0)  begin n_err++; $display("FAIL two_clk_pre: got %b expected 0", clk_o[0]); end
    tick();
    n_cmp++; if (stb_o[0] !== 1'b1)  begin n_err++; $display("FAIL two_stb: got %b expected 1", stb_o[0]); end
    n_cmp++; if (pend_o[0] !== 1'b0) begin n_err++; $display("FAIL two_pend_clr: got %b expected 0", pend_o[0]); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = ((k % 3) < 2);
      n_cmp++; if (clk_o[0] !== e) begin n_err++; $display("FAIL two_clk k%0d: got %b expected %b", k, clk_o[0], e); end
      e = ((k % 3) == 0);
      n_cmp++; if (stb_o[0] !== e) begin n_err++; $display("FAIL two_stb k%0d: got %b expected %b", k, stb_o[0], e); end
    end
  endtask

  task automatic test_en_drop();
    tick();
    n_cmp++; if (clk_o[0] !== 1'b1)    begin n_err++; $display("FAIL drop_pre_clk: got %b expected 1", clk_o[0]); end
    n_cmp++; if (locked_o[1] !== 1'b1) begin n_err++; $display("FAIL drop_pre_locked1: got %b expected 1", locked_o[1]); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (clk_o !== 2'b00)    begin n_err++; $display("FAIL drop_clk i%0d: got %b expected 00", i, clk_o); end
      n_cmp++; if (stb_o !== 2'b00)    begin n_err++; $display("FAIL drop_stb i%0d: got %b expected 00", i, stb_o); end
      n_cmp++; if (locked_o !== 2'b00) begin n_err++; $display("FAIL drop_locked i%0d: got %b expected 00", i, locked_o); end
    end
    en = 1'b1;
    tick();
    n_cmp++; if (stb_o !== 2'b11) begin n_err++; $display("FAIL rearm_stb: got %b expected 11", stb_o); end
    n_cmp++; if (clk_o !== 2'b11) begin n_err++; $display("FAIL rearm_clk: got %b expected 11", clk_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b01) begin n_err++; $display("FAIL rearm_clk1: got %b expected 01", clk_o); end
    n_cmp++; if (stb_o !== 2'b00) begin n_err++; $display("FAIL rearm_stb1: got %b expected 00", stb_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b10) begin n_err++; $display("FAIL rearm_clk2: got %b expected 10", clk_o); end
    n_cmp++; if (stb_o !== 2'b10) begin n_err++; $display("FAIL rearm_stb2: got %b expected 10", stb_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b01) begin n_err++; $display("FAIL rearm_clk3: got %b expected 01", clk_o); end
    n_cmp++; if (stb_o !== 2'b01) begin n_err++; $display("FAIL rearm_stb3: got %b expected 01", stb_o); end
  endtask

  task automatic test_reset_mid();
    logic e;
    div[7:0] = 8'd9; load = 2'b01;
    tick();
    load = 2'b00;
    n_cmp++; if (pend_o !== 2'b01) begin n_err++; $display("FAIL rmid_pend: got %b expected 01", pend_o); end
    n_cmp++; if (clk_o !== 2'b11)  begin n_err++; $display("FAIL rmid_clk_pre: got %b expected 11", clk_o); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (clk_o !== 2'b00)  begin n_err++; $display("FAIL rmid_clk: got %b expected 00", clk_o); end
    n_cmp++; if (stb_o !== 2'b00)  begin n_err++; $display("FAIL rmid_stb: got %b expected 00", stb_o); end
    n_cmp++; if (pend_o !== 2'b00) begin n_err++; $display("FAIL rmid_pend_clr: got %b expected 00", pend_o); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = (i % 2 == 0);
      n_cmp++; if (clk_o !== {e, e}) begin n_err++; $display("FAIL rmid_clk i%0d: got %b expected %b", i, clk_o, {e, e}); end
      n_cmp++; if (stb_o !== {e, e}) begin n_err++; $display("FAIL rmid_stb i%0d: got %b expected %b", i, stb_o, {e, e}); end
      n_cmp++; if (pend_o !== 2'b00) begin n_err++; $display("FAIL rmid_pend i%0d: got %b expected 00", i, pend_o); end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    en = 1'b0;
    tick();
    div = {8'd4, 8'd3}; load = 2'b11;
    tick();
    load = 2'b00; en = 1'b1;
    tick();
    tick();
    n_cmp++; if (stb_o !== 2'b00) begin n_err++; $display("FAIL sync_pre_stb: got %b expected 00", stb_o); end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    n_cmp++; if (stb_o !== 2'b11) begin n_err++; $display("FAIL sync_stb: got %b expected 11", stb_o); end
    n_cmp++; if (clk_o !== 2'b11) begin n_err++; $display("FAIL sync_clk: got %b expected 11", clk_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b11) begin n_err++; $display("FAIL sync_clk1: got %b expected 11", clk_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b00) begin n_err++; $display("FAIL sync_clk2: got %b expected 00", clk_o); end
    tick();
    n_cmp++; if (clk_o !== 2'b01) begin n_err++; $display("FAIL sync_clk3: got %b expected 01", clk_o); end
    n_cmp++; if (stb_o !== 2'b01) begin n_err++; $display("FAIL sync_stb3: got %b expected 01", stb_o); end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; div = '0; load = '0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
    test_reset();
    test_default();
    test_load_mid();
    test_sanitise();
    test_div255();
    test_two_loads();
    test_en_drop();
    test_reset_mid();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
